// File: rtl/turbo_itl_pp_if.sv
// Handshake bundle between a symbol source/sink and turbo_itl_pp.
//   pb_size   : block mode sampled on the first beat of a block (3 is illegal)
//   din       : input symbol, W bits
//   din_vld   : din valid
//   din_rdy   : block buffer can take din this cycle
//   dout      : symbol in natural order
//   dout_itl  : symbol in interleaved order
//   dout_vld  : dout/dout_itl/dout_last valid
//   dout_rdy  : downstream accepts the output beat
//   dout_last : final beat of a block, qualified by dout_vld
//   err       : one-cycle pulse for an illegal pb_size at block start
// slave is the interleaver's view; master is the source/sink view.
interface turbo_itl_pp_if #(
    parameter int W = 2
);
    logic [1:0]   pb_size;
    logic [W-1:0] din;
    logic         din_vld;
    logic         din_rdy;
    logic [W-1:0] dout;
    logic [W-1:0] dout_itl;
    logic         dout_vld;
    logic         dout_rdy;
    logic         dout_last;
    logic         err;

    modport slave (
        input  pb_size, din, din_vld, dout_rdy,
        output din_rdy, dout, dout_itl, dout_vld, dout_last, err
    );

    modport master (
        output pb_size, din, din_vld, dout_rdy,
        input  din_rdy, dout, dout_itl, dout_vld, dout_last, err
    );
endinterface

// File: rtl/turbo_itl_pp.sv
// Ping-pong block interleaver. A writer fills one bank with a block of L
// symbols in natural order while a reader streams the other bank out, giving
// each symbol at index j together with the symbol at p(j) = (S*j) mod L.
// Ports:
//   clk   : rising-edge clock
//   n_rst : asynchronous active-low reset
//   bus   : turbo_itl_pp_if.slave (input stream, output stream, err)
module turbo_itl_pp #(
    parameter int W  = 2,
    parameter int L0 = 64,
    parameter int L1 = 544,
    parameter int L2 = 2080,
    parameter int S0 = 37,
    parameter int S1 = 37,
    parameter int S2 = 37,
    parameter int AW = 12
) (
    input  logic          clk,
    input  logic          n_rst,
    turbo_itl_pp_if.slave bus
);
    localparam int DEPTH = 1 << AW;
    localparam int LM0 = L0 - 1;
    localparam int LM1 = L1 - 1;
    localparam int LM2 = L2 - 1;

    typedef enum logic [1:0] {RD_IDLE, RD_READ, RD_DRAIN} rd_state_t;
    typedef struct packed {
        logic         last;
        logic [W-1:0] itl;
        logic [W-1:0] nat;
    } beat_t;

    // Index of the final beat of a block for a given mode.
    function automatic logic [AW-1:0] last_idx(input logic [1:0] mode);
        case (mode)
            2'd0:    last_idx = LM0[AW-1:0];
            2'd1:    last_idx = LM1[AW-1:0];
            default: last_idx = LM2[AW-1:0];
        endcase
    endfunction

    function automatic logic [AW:0] blk_len(input logic [1:0] mode);
        case (mode)
            2'd0:    blk_len = L0[AW:0];
            2'd1:    blk_len = L1[AW:0];
            default: blk_len = L2[AW:0];
        endcase
    endfunction

    // Strides are assumed smaller than their block length, so one
    // conditional subtract is enough to wrap p.
    function automatic logic [AW-1:0] stride(input logic [1:0] mode);
        case (mode)
            2'd0:    stride = S0[AW-1:0];
            2'd1:    stride = S1[AW-1:0];
            default: stride = S2[AW-1:0];
        endcase
    endfunction

    // ---------------------------------------------------------------- writer
    logic          run;          // holds din_rdy low until the first edge after reset
    logic          wr_bank;
    logic [AW-1:0] wr_cnt;
    logic [1:0]    full;
    logic [1:0]    bank_mode [2];
    logic          err_q;
    logic          din_rdy;
    logic          wr_first, accept, bad_mode, wr_en, wr_done;
    logic [1:0]    wr_mode;

    always_comb begin
        wr_first = (wr_cnt == '0);
        // The first beat defines the mode; later beats use the latched one.
        wr_mode  = wr_first ? bus.pb_size : bank_mode[wr_bank];
        din_rdy  = run && !full[wr_bank];
        accept   = bus.din_vld && din_rdy;
        bad_mode = accept && wr_first && (bus.pb_size == 2'd3);
        wr_en    = accept && !bad_mode;
        wr_done  = wr_en && (wr_cnt == last_idx(wr_mode));
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            run          <= 1'b0;
            wr_bank      <= 1'b0;
            wr_cnt       <= '0;
            err_q        <= 1'b0;
            bank_mode[0] <= 2'd0;
            bank_mode[1] <= 2'd0;
        end else begin
            run   <= 1'b1;
            err_q <= bad_mode;
            if (wr_en && wr_first) bank_mode[wr_bank] <= bus.pb_size;
            if (wr_done) begin
                wr_cnt  <= '0;
                wr_bank <= ~wr_bank;
            end else if (wr_en) begin
                wr_cnt <= wr_cnt + AW'(1);
            end
        end
    end

    // ---------------------------------------------------------------- reader
    rd_state_t     state, state_nx;
    logic          rd_bank;
    logic [AW-1:0] rd_idx, p, p_next;
    logic [AW:0]   p_sum;
    logic          rd_at_end, issue, rel;

    // Output side: RAM read register plus a 2-entry skid FIFO.
    beat_t         rd_beat;
    logic          rd_vld;
    beat_t         fifo [2];
    logic          fifo_wp, fifo_rp;
    logic [1:0]    fifo_cnt, occ;
    logic          fifo_empty, out_vld, take, push, pop, room;
    beat_t         head, out_beat;

    always_comb begin
        rd_at_end = (rd_idx == last_idx(bank_mode[rd_bank]));
        p_sum     = {1'b0, p} + {1'b0, stride(bank_mode[rd_bank])};
        p_next    = AW'((p_sum >= blk_len(bank_mode[rd_bank])) ?
                        p_sum - blk_len(bank_mode[rd_bank]) : p_sum);
    end

    always_comb begin
        fifo_empty = (fifo_cnt == 2'd0);
        out_vld    = !fifo_empty || rd_vld;
        // An empty FIFO lets the RAM register feed the port directly; if that
        // beat stalls it is pushed into the FIFO and stays at the head.
        head       = fifo_empty ? rd_beat : fifo[fifo_rp];
        out_beat   = out_vld ? head : '0;
        take       = out_vld && bus.dout_rdy;
        push       = rd_vld && !(fifo_empty && bus.dout_rdy);
        pop        = !fifo_empty && bus.dout_rdy;
        // Only issue a read if its data is guaranteed a FIFO slot next cycle.
        occ        = fifo_cnt + 2'(rd_vld);
        room       = (occ - 2'(take)) <= 2'd1;
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) state <= RD_IDLE;
        else        state <= state_nx;
    end

    // NOTE: defaulting state_nx before the case keeps every path assigned,
    // so no latch is inferred.
    always_comb begin
        state_nx = state;
        case (state)
            RD_IDLE:  if (full[rd_bank]) state_nx = RD_READ;
            RD_READ:  if (issue && rd_at_end) state_nx = RD_DRAIN;
            RD_DRAIN: if (rel) state_nx = full[~rd_bank] ? RD_READ : RD_IDLE;
            default:  state_nx = RD_IDLE;
        endcase
    end

    always_comb begin
        issue = (state == RD_READ) && room;
        rel   = (state == RD_DRAIN) && take && head.last;
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            rd_bank  <= 1'b0;
            rd_idx   <= '0;
            p        <= '0;
            rd_vld   <= 1'b0;
            fifo_wp  <= 1'b0;
            fifo_rp  <= 1'b0;
            fifo_cnt <= 2'd0;
            full     <= 2'b00;
        end else begin
            rd_vld <= issue;
            if (issue) begin
                rd_idx <= rd_at_end ? '0 : rd_idx + AW'(1);
                p      <= rd_at_end ? '0 : p_next;
            end
            if (rel)  rd_bank <= ~rd_bank;
            if (push) fifo_wp <= ~fifo_wp;
            if (pop)  fifo_rp <= ~fifo_rp;
            fifo_cnt <= fifo_cnt + 2'(push) - 2'(pop);
            // Fill and release always target different banks, so both apply.
            full <= (full | (wr_done ? (wr_bank ? 2'b10 : 2'b01) : 2'b00))
                  & ~(rel ? (rd_bank ? 2'b10 : 2'b01) : 2'b00);
        end
    end

    // ---------------------------------------------------------------- storage
    logic [W-1:0] mem0 [DEPTH];
    logic [W-1:0] mem1 [DEPTH];

    // NOTE: RAM and the FIFO payload are not reset; valid flags guard them
    // and the output mux forces zeros whenever nothing is valid.
    always_ff @(posedge clk) begin
        if (wr_en && !wr_bank) mem0[wr_cnt] <= bus.din;
        if (wr_en &&  wr_bank) mem1[wr_cnt] <= bus.din;
        if (issue) begin
            rd_beat.nat  <= rd_bank ? mem1[rd_idx] : mem0[rd_idx];
            rd_beat.itl  <= rd_bank ? mem1[p] : mem0[p];
            rd_beat.last <= rd_at_end;
        end
        if (push) fifo[fifo_wp] <= rd_beat;
    end

    assign bus.din_rdy   = din_rdy;
    assign bus.dout      = out_beat.nat;
    assign bus.dout_itl  = out_beat.itl;
    assign bus.dout_last = out_beat.last;
    assign bus.dout_vld  = out_vld;
    assign bus.err       = err_q;
endmodule

// File: tb/tb_turbo_itl_pp.sv
// Bench for turbo_itl_pp: block-level reference model (permutation computed
// as (S*j) mod L over a captured block), one per-cycle compare process, and
// directed scenarios with a few hand-computed expectations.
`timescale 1ns/1ps
module tb_turbo_itl_pp;
    localparam int W  = 2;
    localparam int L0 = 64;
    localparam int L1 = 544;
    localparam int L2 = 2080;
    localparam int S  = 37;

    logic clk = 1'b0;
    logic n_rst = 1'b1;
    always #5 clk = ~clk;

    turbo_itl_pp_if #(.W(W)) bus ();
    turbo_itl_pp #(.W(W)) dut (.clk(clk), .n_rst(n_rst), .bus(bus));

    typedef struct {
        logic [W-1:0] nat;
        logic [W-1:0] itl;
        logic         last;
    } exp_t;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int blk_len(input logic [1:0] m);
        case (m)
            2'd0:    return L0;
            2'd1:    return L1;
            default: return L2;
        endcase
    endfunction

    // ------------------------------------------------------------ model state
    exp_t         exp_q [$];
    exp_t         ent, cur;
    logic [W-1:0] part [0:L2-1];
    int           part_cnt = 0;
    logic [1:0]   part_mode = 2'd0;
    int           occ = 0;          // complete blocks held inside the DUT
    bit           err_exp = 1'b0;
    int           post_rst = 0;
    int           cyc = 0;
    int           last_in_cyc = 0;
    bit           stall_prev = 1'b0;
    logic [W-1:0] hold_dout, hold_itl;
    logic         hold_last;
    int           out_idx = 0;
    int           blk_len_seen = 0;
    logic [W-1:0] cap_itl [0:63];
    int           err_pulses = 0;
    int           beats_out = 0;
    int           lasts_out = 0;
    bit           rand_rdy = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    // ------------------------------------------------------------ compare
    always @(negedge clk) begin
        if (!n_rst) begin
            check("rst_dout", bus.dout, 0);
            check("rst_dout_itl", bus.dout_itl, 0);
            check("rst_dout_vld", bus.dout_vld, 0);
            check("rst_dout_last", bus.dout_last, 0);
            check("rst_err", bus.err, 0);
            check("rst_din_rdy", bus.din_rdy, 0);
            exp_q.delete();
            part_cnt   = 0;
            occ        = 0;
            err_exp    = 1'b0;
            post_rst   = 0;
            stall_prev = 1'b0;
            out_idx    = 0;
        end else begin
            check("err", bus.err, err_exp);
            if (bus.err) err_pulses++;
            err_exp = 1'b0;
            // Ready only drops while both banks hold complete blocks.
            check("din_rdy", bus.din_rdy, (post_rst > 0) && (occ < 2));
            post_rst++;
            if (stall_prev) begin
                check("hold_vld", bus.dout_vld, 1);
                check("hold_dout", bus.dout, hold_dout);
                check("hold_itl", bus.dout_itl, hold_itl);
                check("hold_last", bus.dout_last, hold_last);
            end
            if (bus.dout_vld && bus.dout_rdy) begin
                beats_out++;
                check("beat_expected", exp_q.size() != 0, 1);
                if (exp_q.size() != 0) begin
                    cur = exp_q.pop_front();
                    check("dout", bus.dout, cur.nat);
                    check("dout_itl", bus.dout_itl, cur.itl);
                    check("dout_last", bus.dout_last, cur.last);
                    if (cur.last) occ--;
                end
                if (out_idx < 64) cap_itl[out_idx] = bus.dout_itl;
                out_idx++;
                if (bus.dout_last) begin
                    lasts_out++;
                    blk_len_seen = out_idx;
                    out_idx = 0;
                end
            end
            stall_prev = bus.dout_vld && !bus.dout_rdy;
            hold_dout  = bus.dout;
            hold_itl   = bus.dout_itl;
            hold_last  = bus.dout_last;
            if (bus.din_vld && bus.din_rdy) begin
                if (part_cnt == 0 && bus.pb_size == 2'd3) begin
                    err_exp = 1'b1;
                end else begin
                    if (part_cnt == 0) part_mode = bus.pb_size;
                    part[part_cnt] = bus.din;
                    part_cnt++;
                    if (part_cnt == blk_len(part_mode)) begin
                        for (int j = 0; j < part_cnt; j++) begin
                            ent.nat  = part[j];
                            ent.itl  = part[(S * j) % part_cnt];
                            ent.last = (j == part_cnt - 1);
                            exp_q.push_back(ent);
                        end
                        part_cnt    = 0;
                        occ++;
                        last_in_cyc = cyc;
                    end
                end
            end
        end
    end

    // ------------------------------------------------------------ stimulus
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // pat 0: k mod 4, pat 1: random, pat 2: markers at k=10 (1) and k=27 (2)
    task automatic send(input int n, input logic [1:0] m0, input int sw_at,
                        input logic [1:0] m1, input int pat);
        int   k = 0;
        int   waits = 0;
        logic acc;
        while (k < n) begin
            bus.din_vld = 1'b1;
            bus.pb_size = (sw_at >= 0 && k >= sw_at) ? m1 : m0;
            case (pat)
                0:       bus.din = W'(k % 4);
                1:       bus.din = W'($urandom);
                default: bus.din = (k == 10) ? 2'd1 : (k == 27) ? 2'd2 : 2'd0;
            endcase
            @(negedge clk);
            acc = bus.din_rdy;
            tick();
            if (acc) begin
                k++;
                waits = 0;
            end else begin
                waits++;
                if (waits > 5000) begin
                    check("din_rdy_wait", acc, 1);
                    bus.din_vld = 1'b0;
                    return;
                end
            end
        end
        bus.din_vld = 1'b0;
    endtask

    task automatic wait_drain(input int budget);
        int n = 0;
        while ((exp_q.size() != 0 || bus.dout_vld) && n < budget) begin
            @(negedge clk);
            n++;
        end
        check("drain_queue", exp_q.size(), 0);
        repeat (5) @(negedge clk);
        tick();
    endtask

    initial begin
        bus.dout_rdy = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            bus.dout_rdy = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        int n, v, base;
        bus.din_vld = 1'b0;
        bus.din     = '0;
        bus.pb_size = 2'd0;
        #1 n_rst = 1'b0;
        repeat (3) @(negedge clk);
        tick();
        n_rst = 1'b1;
        repeat (3) tick();

        // Mode 0, din = k mod 4: latency, gap-free stream, pinned values.
        send(64, 2'd0, -1, 2'd0, 0);
        n = 0;
        while (!bus.dout_vld && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("first_vld_latency", cyc - last_in_cyc, 3);
        v = 0;
        for (int i = 0; i < 64; i++) begin
            if (bus.dout_vld) v++;
            @(negedge clk);
        end
        check("stream_no_gaps", v, 64);
        wait_drain(2000);
        check("blk0_len", blk_len_seen, 64);
        check("blk0_itl5", cap_itl[5], 1);     // p(5)=57, 57 mod 4 = 1

        // Illegal mode on the first beat, then a normal mode-0 block.
        base = err_pulses;
        send(1, 2'd3, -1, 2'd3, 0);
        send(64, 2'd0, -1, 2'd0, 1);
        wait_drain(2000);
        check("err_pulse_count", err_pulses - base, 1);
        check("after_err_len", blk_len_seen, 64);

        // pb_size switched to 2 mid-block is ignored; markers pin p(j).
        send(64, 2'd0, 10, 2'd2, 2);
        wait_drain(2000);
        check("toggle_len", blk_len_seen, 64);
        check("itl_idx2", cap_itl[2], 1);      // p(2)=10
        check("itl_idx63", cap_itl[63], 2);    // p(63)=27
        check("itl_idx0", cap_itl[0], 0);      // p(0)=0

        // Back-to-back blocks of different modes.
        base = lasts_out;
        send(64, 2'd0, -1, 2'd0, 1);
        send(544, 2'd1, -1, 2'd1, 1);
        send(64, 2'd0, -1, 2'd0, 1);
        wait_drain(5000);
        check("mixed_lasts", lasts_out - base, 3);

        // Three full-size blocks with din_vld held high.
        base = beats_out;
        send(3 * L2, 2'd2, -1, 2'd2, 1);
        wait_drain(10000);
        check("three_blk_beats", beats_out - base, 3 * L2);

        // Mode 1 under random backpressure.
        base = lasts_out;
        rand_rdy = 1'b1;
        send(2 * L1, 2'd1, -1, 2'd1, 1);
        wait_drain(10000);
        rand_rdy = 1'b0;
        check("rand_lasts", lasts_out - base, 2);

        // Reset at beat 300 of a second mode-2 block, then one mode-0 block.
        send(L2 + 300, 2'd2, -1, 2'd2, 1);
        n_rst = 1'b0;
        repeat (3) @(negedge clk);
        tick();
        n_rst = 1'b1;
        base = beats_out;
        send(64, 2'd0, -1, 2'd0, 0);
        wait_drain(2000);
        check("post_reset_beats", beats_out - base, 64);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/turbo_itl_pp.md
TURBO_ITL_PP -- requirements
Module: turbo_itl_pp

Interface
REQ-001 SHALL provide parameter W, default 2, symbol width in bits per beat.
REQ-002 SHALL provide parameters L0/L1/L2, defaults 64/544/2080, block length in beats for pb_size 0/1/2.
REQ-003 SHALL provide parameters S0/S1/S2, defaults 37/37/37, interleaver stride per mode; each SHALL be coprime with its L.
REQ-004 SHALL provide parameter AW, default 12, address width; 2^AW SHALL be at least max(L0,L1,L2).
REQ-005 clk  input  1  single clock, rising edge.
REQ-006 n_rst  input  1  reset, asynchronous, active-low.
REQ-007 pb_size  input  2  block mode: 0->L0, 1->L1, 2->L2, 3 illegal.
REQ-008 din  input  W  input symbol.
REQ-009 din_vld  input  1  din valid.
REQ-010 din_rdy  output  1  block can accept din this cycle.
REQ-011 dout  output  W  symbol in natural order.
REQ-012 dout_itl  output  W  symbol in interleaved order.
REQ-013 dout_vld  output  1  dout/dout_itl valid.
REQ-014 dout_rdy  input  1  downstream accepts output.
REQ-015 dout_last  output  1  final beat of a block, qualified by dout_vld.
REQ-016 err  output  1  one-cycle pulse: illegal pb_size at block start.

Function
REQ-017 Two banks (ping/pong), each 2^AW x W, SHALL be written by the writer and read by the reader concurrently.
REQ-018 Input beat accepted iff din_vld && din_rdy; din_rdy = 1 while the current write bank is empty.
REQ-019 pb_size SHALL be sampled on the first accepted beat of a block (write count 0) and stored with that bank; later pb_size changes within the block SHALL be ignored.
REQ-020 First beat with pb_size==3: beat discarded, err pulses next cycle, write count stays 0.
REQ-021 Beat k of a block (k = 0..L-1) SHALL be written to address k of the write bank.
REQ-022 After beat L-1 is accepted the bank SHALL be marked full, the writer SHALL toggle banks, and din_rdy SHALL drop the next cycle if the other bank is still full.
REQ-023 Reader states: IDLE, READ, DRAIN; IDLE->READ when the read bank is full; READ->DRAIN after issuing read index L-1; DRAIN->IDLE (or READ if the other bank is full) when the last beat is accepted downstream.
REQ-024 For read index j, dout SHALL equal the symbol at address j; dout_itl SHALL equal the symbol at address p(j), where p(0)=0 and p(j+1) = (p(j)+S) mod L.
REQ-025 p(j) SHALL be generated incrementally by add-and-conditional-subtract, with no multiplier or divider.
REQ-026 RAM read is synchronous (1 cycle); a 2-entry output skid buffer SHALL ensure no beat is lost or duplicated when dout_rdy deasserts.
REQ-027 While dout_vld && !dout_rdy, dout, dout_itl and dout_last SHALL hold stable.
REQ-028 With dout_rdy held high, the first dout_vld SHALL occur exactly 3 cycles after the cycle that accepts input beat L-1, and the block SHALL then stream one beat per cycle with no gaps.
REQ-029 dout_last SHALL be high only on read index L-1; the bank SHALL be released (marked empty) in the cycle that beat is accepted.
REQ-030 A bank being read and the bank being written SHALL never be the same; simultaneous release of one bank and fill of the other SHALL both take effect.
REQ-031 Back-to-back blocks of different modes SHALL each use their own latched L and S.

Reset
REQ-032 On n_rst low: both banks empty, write/read counters and p = 0, reader IDLE, din_rdy=0, dout=0, dout_itl=0, dout_vld=0, dout_last=0, err=0.
REQ-033 din_rdy SHALL rise the first cycle after n_rst deasserts; RAM contents are not reset.
REQ-034 Reset mid-block SHALL discard all partial and full blocks; no output beat from before reset SHALL appear afterward.

Verification
REQ-035 pb_size=0, din = k mod 4 for k=0..63, dout_rdy=1 -> 64 beats, dout = k mod 4, dout_itl = (37k mod 64) mod 4, first dout_vld 3 cycles after the last input, dout_last on beat 63.
REQ-036 Three consecutive 2080-beat blocks, din_vld=1 continuously -> din_rdy drops only while both banks are full; all 6240 outputs match the model in order.
REQ-037 Random dout_rdy (50%) with mode 1 -> no lost or duplicated beats, outputs stable while stalled, dout_last exactly once per 544 beats.
REQ-038 pb_size=3 on the first beat -> err pulse of one cycle, beat dropped; the next block with pb_size=0 processes normally.
REQ-039 pb_size toggled 0->2 at beat 10 of a mode-0 block -> block length stays 64.
REQ-040 n_rst asserted at beat 300 of a mode-2 block, then a new mode-0 block -> only the 64 mode-0 beats are output, and all outputs equal 0 while in reset.
